mem_arbiter: RTL and testbench

- Sequences the single shared program/data memory between three requesters: instruction fetch (F), datapath load/store (D) and debug loader (X).
- One memory access is issued per cycle at most.
- Read data is steered back to the owning requester after the memory's fixed read latency.
- Replaces the fixed PC/ALU address mux in front of the memory; adds halt draining and debug access while halted.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared program/data memory arbiter for fetch (F), datapath (D) and debug loader (X).
// Optional per-requester grant/conflict statistics are enabled with MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic                  d_req,
    input  logic                  x_req,
    input  logic                  d_we,
    input  logic                  x_we,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] x_wdata,
    output logic                  f_gnt,
    output logic                  d_gnt,
    output logic                  x_gnt,
    output logic                  f_rvalid,
    output logic                  d_rvalid,
    output logic                  x_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  halted,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           f_cnt,
    output logic [15:0]           d_cnt,
    output logic [15:0]           x_cnt,
    output logic [15:0]           conflict_cnt
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_F    = 2'd1;
    localparam logic [1:0] TAG_D    = 2'd2;
    localparam logic [1:0] TAG_X    = 2'd3;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    state_t                state;
    logic [3:0]            starve_cnt;
    logic [1:0]            pipe [READ_LATENCY];
    logic [1:0]            push_tag;
    logic [1:0]            tail;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  x_boost;
    logic                  fd_allow;
    logic                  drain_done;

    // F/D are blocked in the very cycle halt_req is seen in RUN, not only from DRAIN on.
    always_comb begin
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        x_gnt    = 1'b0;
        x_boost  = (state == RUN) && x_req && (starve_cnt == LIMIT);
        fd_allow = (state == RUN) && !halt_req;
        if (reset) begin
            if (x_boost)                x_gnt = 1'b1;
            else if (fd_allow && d_req) d_gnt = 1'b1;
            else if (fd_allow && f_req) f_gnt = 1'b1;
            else if (x_req)             x_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_enable       = f_gnt | d_gnt | x_gnt;
        mem_write_enable = (d_gnt && d_we) || (x_gnt && x_we);
        mem_address      = '0;
        mem_write_data   = '0;
        if (x_gnt)      mem_address = x_addr;
        else if (d_gnt) mem_address = d_addr;
        else if (f_gnt) mem_address = f_addr;
        if (d_gnt && d_we)      mem_write_data = d_wdata;
        else if (x_gnt && x_we) mem_write_data = x_wdata;
    end

    always_comb begin
        push_tag = TAG_NONE;
        if (f_gnt)               push_tag = TAG_F;
        else if (d_gnt && !d_we) push_tag = TAG_D;
        else if (x_gnt && !x_we) push_tag = TAG_X;
    end

    assign tail     = pipe[READ_LATENCY-1];
    assign f_rvalid = reset && (tail == TAG_F);
    assign d_rvalid = reset && (tail == TAG_D);
    assign x_rvalid = reset && (tail == TAG_X);
    assign rdata    = (reset && tail != TAG_NONE) ? mem_read_data : rdata_q;
    assign halted   = (state == HALTED);

    // Drain completes on the pipeline's next contents, so the tail being delivered now does not count.
    always_comb begin
        drain_done = (push_tag != TAG_F) && (push_tag != TAG_D);
        for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) begin
            if (pipe[i] == TAG_F || pipe[i] == TAG_D) drain_done = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= RUN;
            starve_cnt <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= TAG_NONE;
        end else begin
            pipe[0] <= push_tag;
            for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
            if (tail != TAG_NONE) rdata_q <= mem_read_data;
            if (!x_req || x_gnt)       starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
            case (state)
                RUN:     if (halt_req) state <= DRAIN;
                DRAIN:   if (drain_done) state <= HALTED;
                HALTED:  if (resume && !halt_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic conflict;
    assign conflict = (f_req && d_req) || (f_req && x_req) || (d_req && x_req);

    always_ff @(posedge clock) begin
        if (!reset) begin
            f_cnt        <= '0;
            d_cnt        <= '0;
            x_cnt        <= '0;
            conflict_cnt <= '0;
        end else begin
            if (f_gnt && f_cnt != 16'hFFFF) f_cnt <= f_cnt + 16'd1;
            if (d_gnt && d_cnt != 16'hFFFF) d_cnt <= d_cnt + 16'd1;
            if (x_gnt && x_cnt != 16'hFFFF) x_cnt <= x_cnt + 16'd1;
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A uses READ_LATENCY=1, instance B READ_LATENCY=2.
// Both share stimulus; each has its own behavioural memory with the matching latency.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req, x_req, d_we, x_we;
    logic [7:0]  f_addr, d_addr, x_addr;
    logic [15:0] d_wdata, x_wdata;
    logic        halt_req, resume;

    logic        a_f_gnt, a_d_gnt, a_x_gnt, a_f_rvalid, a_d_rvalid, a_x_rvalid;
    logic [15:0] a_rdata, a_mem_write_data, a_mem_read_data;
    logic        a_halted, a_mem_enable, a_mem_write_enable;
    logic [7:0]  a_mem_address;

    logic        b_f_gnt, b_d_gnt, b_x_gnt, b_f_rvalid, b_d_rvalid, b_x_rvalid;
    logic [15:0] b_rdata, b_mem_write_data, b_mem_read_data;
    logic        b_halted, b_mem_enable, b_mem_write_enable;
    logic [7:0]  b_mem_address;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] a_f_cnt, a_d_cnt, a_x_cnt, a_conflict_cnt;
    logic [15:0] b_f_cnt, b_d_cnt, b_x_cnt, b_conflict_cnt;
`endif

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] b_stage;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1), .STARVE_LIMIT(4)) u_a (
        .clock(clock), .reset(reset),
        .f_req(f_req), .d_req(d_req), .x_req(x_req), .d_we(d_we), .x_we(x_we),
        .f_addr(f_addr), .d_addr(d_addr), .x_addr(x_addr),
        .d_wdata(d_wdata), .x_wdata(x_wdata),
        .f_gnt(a_f_gnt), .d_gnt(a_d_gnt), .x_gnt(a_x_gnt),
        .f_rvalid(a_f_rvalid), .d_rvalid(a_d_rvalid), .x_rvalid(a_x_rvalid),
        .rdata(a_rdata), .halt_req(halt_req), .resume(resume), .halted(a_halted),
        .mem_enable(a_mem_enable), .mem_write_enable(a_mem_write_enable),
        .mem_address(a_mem_address), .mem_write_data(a_mem_write_data),
        .mem_read_data(a_mem_read_data)
`ifdef MEM_ARB_STATS_EN
        , .f_cnt(a_f_cnt), .d_cnt(a_d_cnt), .x_cnt(a_x_cnt), .conflict_cnt(a_conflict_cnt)
`endif
    );

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(2), .STARVE_LIMIT(4)) u_b (
        .clock(clock), .reset(reset),
        .f_req(f_req), .d_req(d_req), .x_req(x_req), .d_we(d_we), .x_we(x_we),
        .f_addr(f_addr), .d_addr(d_addr), .x_addr(x_addr),
        .d_wdata(d_wdata), .x_wdata(x_wdata),
        .f_gnt(b_f_gnt), .d_gnt(b_d_gnt), .x_gnt(b_x_gnt),
        .f_rvalid(b_f_rvalid), .d_rvalid(b_d_rvalid), .x_rvalid(b_x_rvalid),
        .rdata(b_rdata), .halt_req(halt_req), .resume(resume), .halted(b_halted),
        .mem_enable(b_mem_enable), .mem_write_enable(b_mem_write_enable),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
        .mem_read_data(b_mem_read_data)
`ifdef MEM_ARB_STATS_EN
        , .f_cnt(b_f_cnt), .d_cnt(b_d_cnt), .x_cnt(b_x_cnt), .conflict_cnt(b_conflict_cnt)
`endif
    );

    // Memory models: synchronous write, read data valid READ_LATENCY cycles after issue.
    always @(posedge clock) begin
        if (a_mem_enable && a_mem_write_enable) mem_a[a_mem_address] <= a_mem_write_data;
        if (a_mem_enable && !a_mem_write_enable) a_mem_read_data <= mem_a[a_mem_address];
        if (b_mem_enable && b_mem_write_enable) mem_b[b_mem_address] <= b_mem_write_data;
        b_stage <= (b_mem_enable && !b_mem_write_enable) ? mem_b[b_mem_address] : 16'h0000;
        b_mem_read_data <= b_stage;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; d_req = 0; x_req = 0; d_we = 0; x_we = 0;
        f_addr = '0; d_addr = '0; x_addr = '0; d_wdata = '0; x_wdata = '0;
        halt_req = 0; resume = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        step();
        @(negedge clock);
        checks++;
        if ({a_f_gnt, a_d_gnt, a_x_gnt, a_mem_enable} !== 4'b0) begin
            errors++; $display("FAIL reset_gnt_during got=%b want=0000", {a_f_gnt, a_d_gnt, a_x_gnt, a_mem_enable});
        end
        step();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({a_f_gnt, a_d_gnt, a_x_gnt, a_f_rvalid, a_d_rvalid, a_x_rvalid, a_mem_enable, a_halted, b_halted} !== 9'b0) begin
                errors++; $display("FAIL reset_idle_ctrl cyc=%0d got=%b want=0", i,
                    {a_f_gnt, a_d_gnt, a_x_gnt, a_f_rvalid, a_d_rvalid, a_x_rvalid, a_mem_enable, a_halted, b_halted});
            end
            checks++;
            if (a_rdata !== 16'h0000 || a_mem_address !== 8'h00) begin
                errors++; $display("FAIL reset_idle_data cyc=%0d rdata=%h addr=%h want 0", i, a_rdata, a_mem_address);
            end
            step();
        end
    endtask

    task automatic test_conflict();
        do_reset();
        mem_a[8'h20] = 16'hBEEF;
        mem_a[8'h05] = 16'h0505;
        f_req = 1; d_req = 1; d_we = 0; d_addr = 8'h20; f_addr = 8'h05;
        @(negedge clock);
        checks++;
        if (a_d_gnt !== 1'b1 || a_f_gnt !== 1'b0 || a_mem_address !== 8'h20 || a_mem_enable !== 1'b1) begin
            errors++; $display("FAIL conflict_c0 d_gnt=%b f_gnt=%b addr=%h want 1 0 20", a_d_gnt, a_f_gnt, a_mem_address);
        end
        step();
        d_req = 0;
        @(negedge clock);
        checks++;
        if (a_d_rvalid !== 1'b1 || a_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL conflict_c1_rdata d_rvalid=%b rdata=%h want 1 beef", a_d_rvalid, a_rdata);
        end
        checks++;
        if (a_f_gnt !== 1'b1 || a_mem_address !== 8'h05) begin
            errors++; $display("FAIL conflict_c1_fgnt f_gnt=%b addr=%h want 1 05", a_f_gnt, a_mem_address);
        end
        step();
        f_req = 0;
        @(negedge clock);
        checks++;
        if (a_f_rvalid !== 1'b1 || a_d_rvalid !== 1'b0 || a_rdata !== 16'h0505) begin
            errors++; $display("FAIL conflict_c2 f_rvalid=%b d_rvalid=%b rdata=%h want 1 0 0505", a_f_rvalid, a_d_rvalid, a_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        do_reset();
        x_req = 1; x_we = 0; x_addr = 8'h10; f_req = 1; f_addr = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (a_f_gnt !== 1'b1 || a_x_gnt !== 1'b0) begin
                errors++; $display("FAIL starve_wait cyc=%0d f_gnt=%b x_gnt=%b want 1 0", i, a_f_gnt, a_x_gnt);
            end
            step();
        end
        @(negedge clock);
        checks++;
        if (a_x_gnt !== 1'b1 || a_f_gnt !== 1'b0 || a_mem_address !== 8'h10) begin
            errors++; $display("FAIL starve_promote x_gnt=%b f_gnt=%b addr=%h want 1 0 10", a_x_gnt, a_f_gnt, a_mem_address);
        end
        step();
        @(negedge clock);
        checks++;
        if (a_f_gnt !== 1'b1 || a_x_gnt !== 1'b0 || a_x_rvalid !== 1'b1) begin
            errors++; $display("FAIL starve_after f_gnt=%b x_gnt=%b x_rvalid=%b want 1 0 1", a_f_gnt, a_x_gnt, a_x_rvalid);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_store();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 16'h1234;
        @(negedge clock);
        checks++;
        if (a_d_gnt !== 1'b1 || a_mem_write_enable !== 1'b1 || a_mem_address !== 8'h40 || a_mem_write_data !== 16'h1234) begin
            errors++; $display("FAIL store_strobe gnt=%b we=%b addr=%h wdata=%h want 1 1 40 1234",
                a_d_gnt, a_mem_write_enable, a_mem_address, a_mem_write_data);
        end
        step();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (a_d_rvalid !== 1'b0 || a_mem_enable !== 1'b0 || a_mem_write_data !== 16'h0000) begin
            errors++; $display("FAIL store_no_rvalid d_rvalid=%b en=%b wdata=%h want 0 0 0000", a_d_rvalid, a_mem_enable, a_mem_write_data);
        end
        step();
        x_req = 1; x_we = 0; x_addr = 8'h40;
        @(negedge clock);
        checks++;
        if (a_x_gnt !== 1'b1 || a_mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL store_xread_gnt x_gnt=%b we=%b want 1 0", a_x_gnt, a_mem_write_enable);
        end
        step();
        x_req = 0;
        @(negedge clock);
        checks++;
        if (a_x_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin
            errors++; $display("FAIL store_readback x_rvalid=%b rdata=%h want 1 1234", a_x_rvalid, a_rdata);
        end
        step();
        @(negedge clock);
        checks++;
        if (a_x_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin
            errors++; $display("FAIL rdata_hold x_rvalid=%b rdata=%h want 0 1234", a_x_rvalid, a_rdata);
        end
        step();
    endtask

    task automatic test_halt();
        do_reset();
        mem_b[8'h08] = 16'hCAFE;
        mem_b[8'h30] = 16'h3030;
        f_req = 1; f_addr = 8'h08;
        @(negedge clock);
        checks++;
        if (b_f_gnt !== 1'b1) begin
            errors++; $display("FAIL halt_c0_fgnt f_gnt=%b want 1", b_f_gnt);
        end
        step();
        halt_req = 1;
        @(negedge clock);
        checks++;
        if (b_f_gnt !== 1'b0 || b_mem_enable !== 1'b0 || b_halted !== 1'b0) begin
            errors++; $display("FAIL halt_c1_block f_gnt=%b en=%b halted=%b want 0 0 0", b_f_gnt, b_mem_enable, b_halted);
        end
        step();
        @(negedge clock);
        checks++;
        if (b_f_rvalid !== 1'b1 || b_rdata !== 16'hCAFE || b_halted !== 1'b0 || b_f_gnt !== 1'b0) begin
            errors++; $display("FAIL halt_c2_drain f_rvalid=%b rdata=%h halted=%b f_gnt=%b want 1 cafe 0 0",
                b_f_rvalid, b_rdata, b_halted, b_f_gnt);
        end
        step();
        x_req = 1; x_we = 0; x_addr = 8'h30;
        @(negedge clock);
        checks++;
        if (b_halted !== 1'b1 || b_x_gnt !== 1'b0 + 1'b1 || b_f_gnt !== 1'b0) begin
            errors++; $display("FAIL halt_c3_halted halted=%b x_gnt=%b f_gnt=%b want 1 1 0", b_halted, b_x_gnt, b_f_gnt);
        end
        step();
        x_req = 0;
        step();
        @(negedge clock);
        checks++;
        if (b_x_rvalid !== 1'b1 || b_rdata !== 16'h3030 || b_halted !== 1'b1) begin
            errors++; $display("FAIL halt_xread x_rvalid=%b rdata=%h halted=%b want 1 3030 1", b_x_rvalid, b_rdata, b_halted);
        end
        step();
        halt_req = 0; resume = 1;
        @(negedge clock);
        checks++;
        if (b_halted !== 1'b1 || b_f_gnt !== 1'b0) begin
            errors++; $display("FAIL halt_resume_cyc halted=%b f_gnt=%b want 1 0", b_halted, b_f_gnt);
        end
        step();
        resume = 0;
        @(negedge clock);
        checks++;
        if (b_halted !== 1'b0 || b_f_gnt !== 1'b1) begin
            errors++; $display("FAIL halt_resumed halted=%b f_gnt=%b want 0 1", b_halted, b_f_gnt);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        mem_a[8'h20] = 16'hBEEF;
        x_req = 1; f_req = 1; x_addr = 8'h11; f_addr = 8'h02;
        step();
        step();
        d_req = 1; d_we = 0; d_addr = 8'h20;
        @(negedge clock);
        checks++;
        if (a_d_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_dgnt d_gnt=%b want 1", a_d_gnt);
        end
        step();
        d_req = 0;
        reset = 0;
        @(negedge clock);
        checks++;
        if (a_d_rvalid !== 1'b0 || a_mem_enable !== 1'b0) begin
            errors++; $display("FAIL rstmid_during d_rvalid=%b en=%b want 0 0", a_d_rvalid, a_mem_enable);
        end
        step();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (a_f_gnt !== 1'b1 || a_x_gnt !== 1'b0 || a_d_rvalid !== 1'b0 || a_halted !== 1'b0) begin
                errors++; $display("FAIL rstmid_after cyc=%0d f_gnt=%b x_gnt=%b d_rvalid=%b halted=%b want 1 0 0 0",
                    i, a_f_gnt, a_x_gnt, a_d_rvalid, a_halted);
            end
            step();
        end
        @(negedge clock);
        checks++;
        if (a_x_gnt !== 1'b1 || a_d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_starve x_gnt=%b d_rvalid=%b want 1 0", a_x_gnt, a_d_rvalid);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'(i * 3);
            mem_b[i] = 16'(i * 5);
        end
        test_reset();
        test_conflict();
        test_starvation();
        test_store();
        test_halt();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
